// File: rtl/music_pkg.sv
// music_pkg: note codes, 100 MHz half-period table, code-to-half-period mapping and FSM states.
package music_pkg;
    localparam logic [7:0] NOTE_REST = 8'd0;
    localparam logic [7:0] NOTE_A1 = 8'd21;
    localparam logic [7:0] NOTE_C = 8'd24;
    localparam logic [7:0] NOTE_D = 8'd26;
    localparam logic [7:0] NOTE_E = 8'd28;
    localparam logic [7:0] NOTE_F = 8'd29;
    localparam logic [7:0] NOTE_G = 8'd31;
    localparam logic [7:0] NOTE_A = 8'd33;
    localparam logic [7:0] NOTE_B = 8'd35;
    localparam logic [7:0] NOTE_C2 = 8'd36;
    localparam logic [7:0] NOTE_D2 = 8'd38;
    localparam logic [7:0] NOTE_E2 = 8'd40;
    localparam logic [7:0] NOTE_F2 = 8'd41;
    localparam logic [7:0] NOTE_G2 = 8'd43;

    // C4..B4 half periods in 100 MHz clocks, sharps included
    localparam logic [19:0] HP_TABLE [12] = '{
        20'd191113, 20'd180386, 20'd170262, 20'd160706, 20'd151686, 20'd143173,
        20'd135137, 20'd127553, 20'd120394, 20'd113636, 20'd107258, 20'd101239
    };

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, DONE} state_t;

    function automatic logic [19:0] note_hp(input logic [7:0] code);
        logic [19:0] hp;
        hp = 20'd0;
        if (code >= 8'd12 && code <= 8'd23) hp = HP_TABLE[4'(code - 8'd12)] << 1;
        else if (code >= 8'd24 && code <= 8'd35) hp = HP_TABLE[4'(code - 8'd24)];
        else if (code >= 8'd36 && code <= 8'd47) hp = HP_TABLE[4'(code - 8'd36)] >> 1;
        return hp;
    endfunction
endpackage

// File: rtl/tone_gen.sv
// tone_gen: square wave toggling every half_period clocks; zero half period means silence.
module tone_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [19:0] half_period,
    input  logic        tie,
    output logic        tone_out
);
    logic [19:0] hp_q, hp_d, phase_q, phase_d;
    logic tone_q, tone_d;

    always_comb begin
        hp_d = load ? half_period : hp_q;
        phase_d = phase_q + 20'd1;
        tone_d = tone_q;
        if ((load && !tie) || hp_q == 20'd0) begin
            phase_d = 20'd0;
            tone_d = 1'b0;
        end else if (phase_q == hp_q - 20'd1) begin
            phase_d = 20'd0;
            tone_d = !tone_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp_q <= 20'd0;
            phase_q <= 20'd0;
            tone_q <= 1'b0;
        end else begin
            hp_q <= hp_d;
            phase_q <= phase_d;
            tone_q <= tone_d;
        end
    end

    assign tone_out = tone_q;
endmodule

// File: rtl/music_player.sv
// music_player: steps through the note ROM at a fixed tempo and drives a buzzer square wave.
// Define MUSIC_LOOP_EN to repeat the song until stop instead of ending with a done pulse.
module music_player import music_pkg::*; #(
    parameter int SONG_LEN = 243,
    parameter int TICKS_PER_STEP = 12_500_000,
    parameter int HP_SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play,
    input  logic       stop,
    output logic [7:0] address,
    input  logic [7:0] note,
    output logic [7:0] note_cur,
    output logic       busy,
    output logic       done,
    output logic       tone_out
);
    state_t state_q, state_d;
    logic [7:0] address_q, address_d, note_cur_q, note_cur_d;
    logic [31:0] tempo_q, tempo_d;
    logic busy_q, busy_d, done_q, done_d;
    logic tg_load, tg_tie, last;
    logic [19:0] hp_raw, tg_hp;

    always_comb begin
        state_d = state_q;
        address_d = address_q;
        note_cur_d = note_cur_q;
        tempo_d = tempo_q;
        hp_raw = note_hp(note) >> HP_SHIFT;
        last = address_q == 8'(SONG_LEN - 1);
        tg_load = 1'b0;
        tg_tie = 1'b0;
        tg_hp = (hp_raw != 20'd0 && hp_raw < 20'd2) ? 20'd2 : hp_raw;
        if (state_q != IDLE && stop) begin
            state_d = IDLE;
            address_d = 8'd0;
            note_cur_d = 8'd0;
            tempo_d = 32'd0;
            tg_load = 1'b1;
            tg_hp = 20'd0;
        end else begin
            case (state_q)
                IDLE: if (play && !stop) begin
                    state_d = FETCH;
                    address_d = 8'd0;
                end
                FETCH: state_d = LATCH;
                LATCH: begin
                    note_cur_d = note;
                    tempo_d = 32'(TICKS_PER_STEP - 3);
                    tg_load = 1'b1;
                    tg_tie = note == note_cur_q;
                    state_d = PLAY;
                end
                PLAY: if (tempo_q == 32'd0) begin
`ifdef MUSIC_LOOP_EN
                    address_d = last ? 8'd0 : address_q + 8'd1;
                    state_d = FETCH;
`else
                    address_d = last ? address_q : address_q + 8'd1;
                    state_d = last ? DONE : FETCH;
`endif
                end else begin
                    tempo_d = tempo_q - 32'd1;
                end
                DONE: begin
                    // silence the buzzer once the song has ended naturally
                    address_d = 8'd0;
                    state_d = IDLE;
                    tg_load = 1'b1;
                    tg_hp = 20'd0;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            address_q <= 8'd0;
            note_cur_q <= 8'd0;
            tempo_q <= 32'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            address_q <= address_d;
            note_cur_q <= note_cur_d;
            tempo_q <= tempo_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    tone_gen u_tone (
        .clk(clk),
        .rst(rst),
        .load(tg_load),
        .half_period(tg_hp),
        .tie(tg_tie),
        .tone_out(tone_out)
    );

    assign address = address_q;
    assign note_cur = note_cur_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule

// File: tb/tb_music_player.sv
// tb_music_player: scoreboard bench for music_player with a 1-cycle registered ROM model.
// Expectations adapt to MUSIC_LOOP_EN when it is defined.
module tb_music_player;
    localparam int SL = 4;
    localparam int T = 600;
    localparam int HS = 10;
    localparam int END_E = 4 * T + 3;

    logic clk = 1'b0, rst = 1'b1, play = 1'b0, stop = 1'b0;
    logic [7:0] address, note_cur;
    logic [7:0] note = 8'd0;
    logic busy, done, tone_out;
    logic [7:0] rom [256];
    logic [7:0] last_note = 8'd0;
    int n_tests = 0, n_fail = 0;

    typedef struct {int addr; int at;} ev_t;
    ev_t addr_q[$];

    music_player #(.SONG_LEN(SL), .TICKS_PER_STEP(T), .HP_SHIFT(HS)) dut (
        .clk(clk), .rst(rst), .play(play), .stop(stop), .address(address), .note(note),
        .note_cur(note_cur), .busy(busy), .done(done), .tone_out(tone_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) note <= rom[address];

    initial begin
        #600000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    function automatic int exp_hp(input logic [7:0] code);
        int base [12] = '{191113, 180386, 170262, 160706, 151686, 143173,
                          135137, 127553, 120394, 113636, 107258, 101239};
        int c = int'(code);
        int h = 0;
        if (c >= 24 && c <= 35) h = base[4'(c - 24)];
        else if (c >= 12 && c <= 23) h = base[4'(c - 12)] * 2;
        else if (c >= 36 && c <= 47) h = base[4'(c - 36)] / 2;
        h = h >> HS;
        if (h == 1) h = 2;
        return h;
    endfunction

    // e = clocks since play was accepted; step k latches its note at e = k*T+2
    function automatic logic exp_tone(input int e);
        int k, j, hp;
        if (e < 2) return 1'b0;
`ifndef MUSIC_LOOP_EN
        if (e > 4 * T) return 1'b0;
`endif
        k = (e - 2) / T;
        if (k > 3) k = 3;
        j = k;
        while (j > 0 && rom[8'(j - 1)] == rom[8'(j)]) j--;
        hp = exp_hp(rom[8'(k)]);
        if (hp == 0) return 1'b0;
        return ((e - 2 - j * T) / hp) % 2 == 1;
    endfunction

    function automatic logic [7:0] exp_note(input int e);
        int k;
        if (e < 2) return last_note;
        k = (e - 2) / T;
`ifdef MUSIC_LOOP_EN
        k = k % 4;
`else
        if (k > 3) k = 3;
`endif
        return rom[8'(k)];
    endfunction

    task automatic watch_song(input logic [7:0] c0, c1, c2, c3);
        logic [7:0] prev_addr;
        logic exp_done, exp_busy;
        ev_t ev;
        rom[0] = c0; rom[1] = c1; rom[2] = c2; rom[3] = c3;
        for (int k = 0; k < SL; k++) addr_q.push_back('{k, k * T});
`ifdef MUSIC_LOOP_EN
        addr_q.push_back('{0, 4 * T});
`else
        addr_q.push_back('{0, 4 * T + 1});
`endif
        @(negedge clk) play = 1'b1;
        @(negedge clk) play = 1'b0;
        prev_addr = 8'hff;
        for (int e = 0; e <= END_E; e++) begin
            if (e > 0) @(negedge clk);
            if (address !== prev_addr) begin
                n_tests++;
                if (addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL addr_event: got unexpected address %0d at e=%0d, want no change", address, e);
                end else begin
                    ev = addr_q.pop_front();
                    if (address !== 8'(ev.addr) || e != ev.at) begin
                        n_fail++;
                        $display("FAIL addr_event: got addr=%0d at e=%0d, want addr=%0d at e=%0d", address, e, ev.addr, ev.at);
                    end
                end
                prev_addr = address;
            end
`ifdef MUSIC_LOOP_EN
            exp_done = 1'b0;
            exp_busy = 1'b1;
`else
            exp_done = e == 4 * T;
            exp_busy = e <= 4 * T;
`endif
            n_tests++;
            if (done !== exp_done) begin
                n_fail++;
                $display("FAIL done: got %b at e=%0d, want %b", done, e, exp_done);
            end
            n_tests++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL busy: got %b at e=%0d, want %b", busy, e, exp_busy);
            end
            n_tests++;
            if (note_cur !== exp_note(e)) begin
                n_fail++;
                $display("FAIL note_cur: got %0d at e=%0d, want %0d", note_cur, e, exp_note(e));
            end
`ifdef MUSIC_LOOP_EN
            if (e <= 4 * T + 1) begin
`else
            begin
`endif
                n_tests++;
                if (tone_out !== exp_tone(e)) begin
                    n_fail++;
                    $display("FAIL tone_out: got %b at e=%0d, want %b", tone_out, e, exp_tone(e));
                end
            end
            play = e == T + 50;
        end
        play = 1'b0;
        n_tests++;
        if (addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL addr_events_left: got %0d pending, want 0", addr_q.size());
            addr_q.delete();
        end
`ifdef MUSIC_LOOP_EN
        stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        n_tests++;
        if ({busy, address} !== 9'd0) begin
            n_fail++;
            $display("FAIL loop_stop: got busy=%b address=%0d, want busy=0 address=0", busy, address);
        end
        last_note = 8'd0;
`else
        last_note = c3;
`endif
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({address, note_cur, busy, done, tone_out} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset: got addr=%0d note_cur=%0d busy=%b done=%b tone=%b, want all 0", address, note_cur, busy, done, tone_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sequence;
        watch_song(8'd33, 8'd45, 8'd24, 8'd31);
    endtask

    task automatic test_rest;
        watch_song(8'd0, 8'd60, 8'd33, 8'd0);
    endtask

    task automatic test_tie;
        watch_song(8'd31, 8'd31, 8'd29, 8'd29);
    endtask

    task automatic test_stop;
        int n;
        int dcount;
        rom[0] = 8'd45; rom[1] = 8'd24; rom[2] = 8'd33; rom[3] = 8'd31;
        @(negedge clk) play = 1'b1;
        @(negedge clk) play = 1'b0;
        n = 0;
        while (address !== 8'd2 && n < 4 * T) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (address !== 8'd2) begin
            n_fail++;
            $display("FAIL stop_reach_step2: got address %0d, want 2", address);
        end
        repeat (130) @(negedge clk);
        n_tests++;
        if ({busy, tone_out, note_cur} !== {1'b1, 1'b1, 8'd33}) begin
            n_fail++;
            $display("FAIL stop_before: got busy=%b tone=%b note_cur=%0d, want 1 1 33", busy, tone_out, note_cur);
        end
        stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        n_tests++;
        if ({busy, tone_out, address, note_cur, done} !== 19'd0) begin
            n_fail++;
            $display("FAIL stop_after: got busy=%b tone=%b addr=%0d note_cur=%0d done=%b, want all 0", busy, tone_out, address, note_cur, done);
        end
        dcount = 0;
        repeat (2 * T) begin
            @(negedge clk);
            if (done || busy || tone_out) dcount++;
        end
        n_tests++;
        if (dcount !== 0) begin
            n_fail++;
            $display("FAIL stop_quiet: got %0d active cycles after stop, want 0", dcount);
        end
        last_note = 8'd0;
    endtask

    task automatic test_play_stop_idle;
        play = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        play = 1'b0;
        stop = 1'b0;
        n_tests++;
        if ({busy, address} !== 9'd0) begin
            n_fail++;
            $display("FAIL play_stop_idle: got busy=%b address=%0d, want 0 0", busy, address);
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if ({busy, done, tone_out} !== 3'd0) begin
            n_fail++;
            $display("FAIL play_stop_idle_hold: got busy=%b done=%b tone=%b, want 0 0 0", busy, done, tone_out);
        end
    endtask

    task automatic test_async_reset;
        rom[0] = 8'd33; rom[1] = 8'd45; rom[2] = 8'd24; rom[3] = 8'd31;
        @(negedge clk) play = 1'b1;
        @(negedge clk) play = 1'b0;
        repeat (T + 100) @(negedge clk);
        n_tests++;
        if ({busy, address, note_cur} !== {1'b1, 8'd1, 8'd45}) begin
            n_fail++;
            $display("FAIL async_pre: got busy=%b addr=%0d note_cur=%0d, want 1 1 45", busy, address, note_cur);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({address, note_cur, busy, done, tone_out} !== 19'd0) begin
            n_fail++;
            $display("FAIL async_reset: got addr=%0d note_cur=%0d busy=%b done=%b tone=%b, want all 0", address, note_cur, busy, done, tone_out);
        end
        @(negedge clk) rst = 1'b0;
        last_note = 8'd0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'd0;
        test_reset;
        test_sequence;
        test_rest;
        test_tie;
        test_stop;
        test_play_stop_idle;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
